// File: rtl/data_mem_responder.sv
// Memory-side responder for the load/store port: one request at a time over
// valid/ready, fixed-latency response, byte-strobed word array mapped at BASE_ADDR.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $fatal(1, "data_mem_responder: LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              we_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic              rd_sel_reg;

  logic              accept;
  logic              commit;
  logic              c_we;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic [3:0]        c_wstrb;
  logic [31:0]       offset;
  logic [31:0]       word_off;
  logic [IDX_W-1:0]  c_idx;
  logic              c_err;
  logic              mem_wr;
  logic              mem_rd;
  logic [31:0]       rd_word;

  assign req_ready = (state_reg == IDLE);
  assign accept    = req_valid && (state_reg == IDLE);

  // With LATENCY==1 the commit happens on the accept edge, so it must use the
  // live request inputs rather than the captured copy.
  assign c_we    = (state_reg == IDLE) ? req_we    : we_reg;
  assign c_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
  assign c_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
  assign c_wstrb = (state_reg == IDLE) ? req_wstrb : wstrb_reg;

  assign commit = (accept && (CNT_INIT == '0)) ||
                  ((state_reg == WAIT) && (cnt_reg == CNT_W'(1)));

  assign offset   = c_addr - BASE_ADDR;
  assign word_off = offset >> 2;
  assign c_idx    = word_off[IDX_W-1:0];
  assign c_err    = (c_addr[1:0] != 2'b00) || (c_addr < BASE_ADDR) ||
                    (word_off >= 32'(DEPTH_WORDS));

  // Reset gates the array so an in-flight request can never land during reset.
  assign mem_wr = commit && !c_err && c_we && !reset;
  assign mem_rd = commit && !c_err && !c_we && !reset;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (mem_wr && c_wstrb[gi]) begin
          mem[c_idx] <= c_wdata[8*gi +: 8];
        end
        if (mem_rd) begin
          rd_byte_reg <= mem[c_idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  // The RAM read register has no reset; a separately reset select flag forces
  // the visible read data to zero for stores, errors, idle and after reset.
  assign rsp_rdata = rd_sel_reg ? rd_word : 32'h0;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      wstrb_reg     <= 4'h0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rd_sel_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            wstrb_reg <= req_wstrb;
            cnt_reg   <= CNT_INIT;
            if (commit) begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= c_err;
              rd_sel_reg    <= !c_err && !c_we;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (commit) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= c_err;
            rd_sel_reg    <= !c_err && !c_we;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rd_sel_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
